// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - four-channel hobby-servo PWM generator with frame-synchronous target sampling.
// Optional per-frame slew limiter compiled in with `define SERVO_SLEW_EN.
module servo_pwm_driver #(
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int MIN_CYCLES   = 50_000,
  parameter int DEG_CYCLES   = 277,
  parameter int RESET_ANGLE  = 90,
  parameter int SLEW_DEG     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  output logic       pwm1,
  output logic       pwm2,
  output logic       pwm3,
  output logic       pwm4,
  output logic       frame_tick,
  output logic       busy
);

  localparam int W = $clog2(FRAME_CYCLES);
  localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYCLES - 1);
  localparam logic [W-1:0] UPD_CNT  = W'(FRAME_CYCLES - 2);
  localparam logic [7:0]   MAX_DEG  = 8'd180;
  localparam logic [7:0]   SLEW     = 8'(SLEW_DEG);
`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  logic [W-1:0] fcnt;
  logic [W-1:0] th    [4];
  logic [7:0]   ang   [4];
  logic [7:0]   tgt   [4];
  logic [7:0]   cur   [4];
  logic [7:0]   tgt_n [4];
  logic [7:0]   cur_n [4];
  logic [3:0]   pwm_q;
  logic         upd;
  logic         wrap;
  logic         busy_n;

  function automatic logic [7:0] clamp(input logic [7:0] a);
    return (a > MAX_DEG) ? MAX_DEG : a;
  endfunction

  // Without the limiter the current angle jumps straight to the target.
  function automatic logic [7:0] step(input logic [7:0] c, input logic [7:0] t);
    logic [7:0] r;
    r = t;
    if (SLEW_ON) begin
      if (c < t)
        r = ((t - c) > SLEW) ? c + SLEW : t;
      else if (c > t)
        r = ((c - t) > SLEW) ? c - SLEW : t;
    end
    return r;
  endfunction

  assign upd  = (fcnt == UPD_CNT);
  assign wrap = (fcnt == LAST_CNT);

  always_comb begin
    ang[0] = angle1;
    ang[1] = angle2;
    ang[2] = angle3;
    ang[3] = angle4;
  end

  always_comb begin
    busy_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tgt_n[i] = upd ? clamp(ang[i]) : tgt[i];
      cur_n[i] = upd ? step(cur[i], tgt_n[i]) : cur[i];
      busy_n   = busy_n | (cur_n[i] != tgt_n[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt       <= '0;
      pwm_q      <= '0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        th[i]  <= '0;
        tgt[i] <= 8'(RESET_ANGLE);
        cur[i] <= 8'(RESET_ANGLE);
      end
    end else begin
      fcnt       <= wrap ? '0 : fcnt + 1'b1;
      frame_tick <= wrap;
      busy       <= busy_n;
      for (int i = 0; i < 4; i++) begin
        tgt[i]   <= tgt_n[i];
        cur[i]   <= cur_n[i];
        pwm_q[i] <= enable && (fcnt < th[i]);
        // Thresholds only change at the wrap so a running pulse is never glitched.
        if (wrap)
          th[i] <= W'(MIN_CYCLES) + W'(cur[i]) * W'(DEG_CYCLES);
      end
    end
  end

  assign pwm1 = pwm_q[0];
  assign pwm2 = pwm_q[1];
  assign pwm3 = pwm_q[2];
  assign pwm4 = pwm_q[3];

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb/tb_servo_pwm_driver.sv - self-checking bench for servo_pwm_driver.
module tb_servo_pwm_driver;

  localparam int FC = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       pwm1, pwm2, pwm3, pwm4;
  logic       frame_tick;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int w [4];
  int ticks, busy_any, busy_mid;

  servo_pwm_driver #(
    .FRAME_CYCLES(FC), .MIN_CYCLES(100), .DEG_CYCLES(4), .RESET_ANGLE(90), .SLEW_DEG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3), .pwm4(pwm4),
    .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_angles(input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] a3, input logic [7:0] a4);
    angle1 = a1; angle2 = a2; angle3 = a3; angle4 = a4;
  endtask

  // Leaves the bench on the negedge sample where fcnt == 0.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 1100);
    if (!frame_tick) check("tick_timeout", 0, 1);
  endtask

  // Samples one whole frame, fcnt = 0 .. FC-1.
  task automatic measure();
    wait_tick();
    for (int i = 0; i < 4; i++) w[i] = 0;
    ticks = 1; busy_any = int'(busy); busy_mid = 0;
    for (int k = 1; k < FC; k++) begin
      @(negedge clk);
      w[0] += int'(pwm1); w[1] += int'(pwm2); w[2] += int'(pwm3); w[3] += int'(pwm4);
      ticks += int'(frame_tick);
      if (busy) busy_any = 1;
      if (k == 500) busy_mid = int'(busy);
    end
  endtask

`ifndef SERVO_SLEW_EN
  typedef struct packed {
    logic [7:0]  a1, a2, a3, a4;
    logic [15:0] w1, w2, w3, w4;
  } vec_t;
  vec_t vecs [5];
`endif

  initial begin
    int n, hi, frames, pre, exp_busy;
    int c [4];
    int exp_w [6];
`ifndef SERVO_SLEW_EN
    vecs[0] = '{8'd0,   8'd180, 8'd200, 8'd45,  16'd100, 16'd820, 16'd820, 16'd280};
    vecs[1] = '{8'd255, 8'd1,   8'd179, 8'd10,  16'd820, 16'd104, 16'd816, 16'd140};
    vecs[2] = '{8'd181, 8'd180, 8'd0,   8'd90,  16'd820, 16'd820, 16'd100, 16'd460};
    vecs[3] = '{8'd45,  8'd46,  8'd135, 8'd170, 16'd280, 16'd284, 16'd640, 16'd780};
    vecs[4] = '{8'd90,  8'd90,  8'd90,  8'd90,  16'd460, 16'd460, 16'd460, 16'd460};
`endif
    exp_w = '{464, 468, 472, 476, 480, 480};
    enable = 1'b1;
    set_angles(8'd90, 8'd90, 8'd90, 8'd90);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_fcnt", dut.fcnt, 0);
    check("reset_pwm", {pwm1, pwm2, pwm3, pwm4}, 0);
    check("reset_tick", frame_tick, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;

    // First frame after release: no pulses, first tick after FC samples.
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      n++;
      hi += int'(pwm1 | pwm2 | pwm3 | pwm4);
    end while (!frame_tick && n < 1100);
    check("first_frame_len", n, FC);
    check("first_frame_pwm", hi, 0);
    measure();
    for (int i = 0; i < 4; i++) check($sformatf("reset_width%0d", i + 1), w[i], 460);
    check("ticks_per_frame", ticks, 1);
    @(negedge clk);
    check("tick_period", frame_tick, 1);

    // Mid-frame glitch on angle2 is ignored.
    repeat (100) @(negedge clk);
    angle2 = 8'd0;
    repeat (200) @(negedge clk);
    angle2 = 8'd180;
    repeat (200) @(negedge clk);
    angle2 = 8'd90;
    measure();
    for (int i = 0; i < 4; i++) check($sformatf("glitch_width%0d", i + 1), w[i], 460);

`ifndef SERVO_SLEW_EN
    foreach (vecs[v]) begin
      wait_tick();
      set_angles(vecs[v].a1, vecs[v].a2, vecs[v].a3, vecs[v].a4);
      measure();
      check($sformatf("vec%0d_w1", v), w[0], 32'(vecs[v].w1));
      check($sformatf("vec%0d_w2", v), w[1], 32'(vecs[v].w2));
      check($sformatf("vec%0d_w3", v), w[2], 32'(vecs[v].w3));
      check($sformatf("vec%0d_w4", v), w[3], 32'(vecs[v].w4));
      check($sformatf("vec%0d_busy", v), busy_any, 0);
    end
    exp_busy = 0;
`else
    wait_tick();
    angle1 = 8'd95;
    pre = 0;
    for (int k = 1; k < FC; k++) begin
      @(negedge clk);
      if (busy) pre = 1;
    end
    check("slew_busy_pre", pre, 1);
    frames = pre;
    for (int f = 0; f < 6; f++) begin
      measure();
      check($sformatf("slew_w1_f%0d", f), w[0], exp_w[f]);
      check($sformatf("slew_w2_f%0d", f), w[1], 460);
      check($sformatf("slew_busy_f%0d", f), busy_mid, (f < 4) ? 1 : 0);
      frames += busy_any;
    end
    check("slew_busy_frames", frames, 5);
    angle1 = 8'd90;
    repeat (7) wait_tick();
    check("slew_settled_busy", busy, 0);
    exp_busy = 1;
`endif

    // Enable dropped mid-pulse, restored at fcnt = 50.
    wait_tick();
    repeat (20) @(negedge clk);
    check("pwm_before_disable", {pwm1, pwm2, pwm3, pwm4}, 4'hf);
    enable = 1'b0;
    @(negedge clk);
    check("pwm_after_disable", {pwm1, pwm2, pwm3, pwm4}, 0);
    check("fcnt_while_disabled", dut.fcnt, 21);
    repeat (29) @(negedge clk);
    check("fcnt_at_reenable", dut.fcnt, 50);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int k = 51; k < FC; k++) begin
      @(negedge clk);
      if (k == 51) check("pwm_reenable_edge", {pwm1, pwm2, pwm3, pwm4}, 4'hf);
      c[0] += int'(pwm1); c[1] += int'(pwm2); c[2] += int'(pwm3); c[3] += int'(pwm4);
    end
    for (int i = 0; i < 4; i++) check($sformatf("partial_width%0d", i + 1), c[i], 410);

    // Async reset mid-pulse at fcnt = 300.
    wait_tick();
    if (exp_busy == 1) angle1 = 8'd120;
    repeat (FC - 1) @(negedge clk);
    repeat (301) @(negedge clk);
    check("fcnt_before_reset", dut.fcnt, 300);
    check("pwm_before_reset", {pwm1, pwm2, pwm3, pwm4}, 4'hf);
    check("busy_before_reset", busy, exp_busy);
    #1 rst_n = 1'b0;
    #1;
    check("pwm_async_reset", {pwm1, pwm2, pwm3, pwm4}, 0);
    check("busy_async_reset", busy, 0);
    angle1 = 8'd90;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fcnt_after_release", dut.fcnt, 1);
    check("cur1_after_release", dut.cur[0], 90);
    check("cur2_after_release", dut.cur[1], 90);
    check("cur3_after_release", dut.cur[2], 90);
    check("cur4_after_release", dut.cur[3], 90);
    check("busy_after_release", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
